lcd_update_sequencer: RTL and testbench
=======================================

LCD_UPDATE_SEQUENCER -- requirements
Module: lcd_update_sequencer

Interface
REQ-001 Parameter STARTUP_CYCLES, default 2000000: cycles idle after reset before the first LCD command (power-on wait).
REQ-002 Parameter CLEAR_CYCLES, default 100000: cycles idle after the clear command (0x01) is accepted.
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 filter_type  input  2  currently selected filter from the filter FSM; may change on any cycle.
REQ-006 lcd_ready  input  1  downstream LCD writer can accept a byte.
REQ-007 lcd_valid  output  1  lcd_rs and lcd_data hold a byte to transfer.
REQ-008 lcd_rs  output  1  0 = command byte, 1 = character data byte.
REQ-009 lcd_data  output  8  byte to write.
REQ-010 busy  output  1  high whenever the block is not in IDLE.
REQ-011 shown_type  output  2  filter_type value of the last completed display update.

Function
REQ-012 Transfer rule: a byte transfers on a rising edge where lcd_valid=1 and lcd_ready=1; while lcd_valid=1 and lcd_ready=0, lcd_valid, lcd_rs and lcd_data hold stable.
REQ-013 Back-to-back transfers: lcd_valid may stay high on the cycle after a transfer, presenting the next byte.
REQ-014 States: STARTUP, INIT, CLR_WAIT, UPDATE, IDLE.
REQ-015 STARTUP: counts STARTUP_CYCLES cycles with lcd_valid=0, then moves to INIT.
REQ-016 INIT: sends the commands 0x38, 0x0C, 0x01 in order (rs=0); after 0x01 is accepted, moves to CLR_WAIT.
REQ-017 CLR_WAIT: lcd_valid=0 for CLEAR_CYCLES cycles, then sends command 0x06 (rs=0); after acceptance, moves to UPDATE.
REQ-018 UPDATE: captures filter_type into a target register on entry, then sends command 0x80 (rs=0), followed by 16 data bytes (rs=1).
REQ-019 The 16 data bytes are the target's ASCII name, left-justified and space-padded (0x20): 00 "NO FILTER", 01 "EDGE DETECT", 10 "BLUR", 11 "INVERT".
REQ-020 Completion of UPDATE: after the 16th data byte is accepted, shown_type takes the target value and the block enters IDLE on the next cycle.
REQ-021 IDLE: lcd_valid=0; when filter_type != shown_type, the block enters UPDATE on the next cycle.
REQ-022 A filter_type change during UPDATE does not abort the update; the REQ-021 check catches it once IDLE is reached.
REQ-023 A filter_type change during STARTUP, INIT or CLR_WAIT has no effect; the first UPDATE uses the value sampled on entry.
REQ-024 Counters are wide enough for their parameters; a parameter value of 0 means zero wait cycles and no wrap.
REQ-025 The character index is 4 bits and runs 0..15 with no wrap beyond the 16th byte.
REQ-026 busy = (state != IDLE).

Reset
REQ-027 While rst_n=0 at a clock edge: state STARTUP, counters 0, lcd_valid=0, lcd_rs=0, lcd_data=0x00, shown_type=2'b00, busy=1.
REQ-028 Reset asserted mid-transfer (including while lcd_valid=1 and lcd_ready=0) abandons that transfer; lcd_valid=0 on the cycle after the reset edge.
REQ-029 Reset always restarts the full STARTUP/INIT sequence.

Verification
REQ-030 STARTUP_CYCLES=10, CLEAR_CYCLES=5, lcd_ready=1, filter_type=00 -> lcd_valid first high 10 cycles after reset release; bytes 0x38,0x0C,0x01; 5 idle cycles; 0x06, 0x80, then "NO FILTER" plus 7 spaces; busy falls; shown_type=00.
REQ-031 In IDLE, filter_type 00->10 -> UPDATE entered on the next cycle; 0x80 then "BLUR" plus 12 spaces (rs=1); shown_type=10; 17 transfers in 17 cycles with lcd_ready=1.
REQ-032 lcd_ready toggled pseudo-randomly -> each byte stays stable while stalled; the byte sequence is identical to REQ-031; no byte is duplicated or dropped.
REQ-033 filter_type 00->01 at the 5th data byte of an update showing 11 -> the "INVERT" update completes with shown_type=11, then a second update sends "EDGE DETECT" and shown_type=01.
REQ-034 rst_n low for 1 cycle during a stalled transfer (lcd_valid=1, lcd_ready=0) -> lcd_valid=0 the next cycle, shown_type=00, busy=1, and the full STARTUP sequence reruns.

Source files
------------

// File: rtl/lcd_update_sequencer_if.sv
// Byte-stream handshake between the LCD update sequencer and the LCD writer.
// The sequencer drives valid/rs/data and the writer answers with ready.
interface lcd_update_sequencer_if;
  logic       lcd_valid;
  logic       lcd_rs;
  logic [7:0] lcd_data;
  logic       lcd_ready;

  modport master (
    output lcd_valid,
    output lcd_rs,
    output lcd_data,
    input  lcd_ready
  );

  modport slave (
    input  lcd_valid,
    input  lcd_rs,
    input  lcd_data,
    output lcd_ready
  );
endinterface

// File: rtl/lcd_update_sequencer.sv
// LCD update sequencer: waits out the LCD power-on time, initialises the
// display, then writes the name of the selected filter on line one. After
// that it rewrites the line whenever filter_type differs from what is shown.
module lcd_update_sequencer #(
  parameter int unsigned STARTUP_CYCLES = 2000000,
  parameter int unsigned CLEAR_CYCLES   = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             filter_type,
  lcd_update_sequencer_if.master lcd,
  output logic                   busy,
  output logic [1:0]             shown_type
);

  localparam int unsigned MAX_CYC = (STARTUP_CYCLES > CLEAR_CYCLES) ? STARTUP_CYCLES : CLEAR_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_INIT,
    ST_CLR_WAIT,
    ST_UPDATE,
    ST_IDLE
  } state_e;

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [3:0]         idx_q,    idx_d;
  logic               hdr_q,    hdr_d;
  logic [1:0]         target_q, target_d;
  logic [1:0]         shown_q,  shown_d;

  logic               startup_done;
  logic               clr_done;
  logic               xfer;

  // Initialisation command for a given position in the init burst.
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // Character i of the 16-character, space-padded filter name.
  function automatic logic [7:0] name_char(input logic [1:0] t, input logic [3:0] i);
    logic [127:0] row;
    logic [6:0]   pos;
    case (t)
      2'b00:   row = {"NO FILTER",   {7{8'h20}}};
      2'b01:   row = {"EDGE DETECT", {5{8'h20}}};
      2'b10:   row = {"BLUR",        {12{8'h20}}};
      default: row = {"INVERT",      {10{8'h20}}};
    endcase
    pos = {4'd15 - i, 3'b000};
    return row[pos +: 8];
  endfunction

  // The counter never climbs past its limit, so zero-length waits cannot wrap.
  assign startup_done = (32'(cnt_q) + 32'd1 >= STARTUP_CYCLES);
  assign clr_done     = (32'(cnt_q) >= CLEAR_CYCLES);
  assign xfer         = lcd.lcd_valid && lcd.lcd_ready;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_STARTUP;
      cnt_q    <= '0;
      idx_q    <= 4'd0;
      hdr_q    <= 1'b0;
      target_q <= 2'b00;
      shown_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      hdr_q    <= hdr_d;
      target_q <= target_d;
      shown_q  <= shown_d;
    end
  end

  // Next-state logic: waits, byte stepping and update triggering.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    hdr_d    = hdr_q;
    target_d = target_q;
    shown_d  = shown_q;
    case (state_q)
      ST_STARTUP: begin
        if (startup_done) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          idx_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_INIT: begin
        if (xfer) begin
          if (idx_q == 4'd2) begin
            state_d = ST_CLR_WAIT;
            cnt_d   = '0;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_CLR_WAIT: begin
        if (!clr_done) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (xfer) begin
          state_d  = ST_UPDATE;
          target_d = filter_type;
          hdr_d    = 1'b0;
          idx_d    = 4'd0;
        end
      end
      ST_UPDATE: begin
        if (xfer) begin
          if (!hdr_q) begin
            hdr_d = 1'b1;
          end else if (idx_q == 4'd15) begin
            shown_d = target_q;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_IDLE: begin
        if (filter_type != shown_q) begin
          state_d  = ST_UPDATE;
          target_d = filter_type;
          hdr_d    = 1'b0;
          idx_d    = 4'd0;
        end
      end
      default: begin
        state_d = ST_STARTUP;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode: byte presentation depends only on registered state, so it holds while stalled.
  always_comb begin
    lcd.lcd_valid = 1'b0;
    lcd.lcd_rs    = 1'b0;
    lcd.lcd_data  = 8'h00;
    case (state_q)
      ST_INIT: begin
        lcd.lcd_valid = 1'b1;
        lcd.lcd_data  = init_cmd(idx_q[1:0]);
      end
      ST_CLR_WAIT: begin
        if (clr_done) begin
          lcd.lcd_valid = 1'b1;
          lcd.lcd_data  = 8'h06;
        end
      end
      ST_UPDATE: begin
        lcd.lcd_valid = 1'b1;
        if (!hdr_q) begin
          lcd.lcd_data = 8'h80;
        end else begin
          lcd.lcd_rs   = 1'b1;
          lcd.lcd_data = name_char(target_q, idx_q);
        end
      end
      default: begin
        lcd.lcd_valid = 1'b0;
      end
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign shown_type = shown_q;

endmodule

// File: tb/tb_lcd_update_sequencer.sv
// Scoreboard bench for lcd_update_sequencer: expected bytes are queued as
// stimulus is issued and a monitor pops and compares every accepted byte.
module tb_lcd_update_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] filter_type;
  logic       busy;
  logic [1:0] shown_type;

  lcd_update_sequencer_if lcd_bus();

  lcd_update_sequencer #(
    .STARTUP_CYCLES(10),
    .CLEAR_CYCLES  (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .filter_type(filter_type),
    .lcd        (lcd_bus),
    .busy       (busy),
    .shown_type (shown_type)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         xfer_count = 0;
  int         release_cyc = 0;
  int         base = 0;
  logic [8:0] sb[$];
  int         xfer_cyc[$];
  logic       stall = 1'b0;
  logic [8:0] held = 9'h0;

  // One comparison, counted; a mismatch prints a FAIL line.
  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic pushByte(input logic rs, input logic [7:0] d);
    sb.push_back({rs, d});
  endtask

  // Header command plus 16 space-padded name characters.
  task automatic pushName(input string s);
    logic [7:0] ch;
    pushByte(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) begin
      ch = (i < s.len()) ? s[i] : 8'h20;
      pushByte(1'b1, ch);
    end
  endtask

  task automatic pushStartup(input string s);
    pushByte(1'b0, 8'h38);
    pushByte(1'b0, 8'h0C);
    pushByte(1'b0, 8'h01);
    pushByte(1'b0, 8'h06);
    pushName(s);
  endtask

  task automatic applyStimulus(input logic [1:0] ft, input logic rdy);
    @(posedge clk);
    #1;
    filter_type = ft;
    lcd_bus.lcd_ready = rdy;
  endtask

  // Returns 1ns after the edge on which transfer number 'target' happens.
  task automatic waitXfers(input int target, input int budget, input string name);
    int n = 0;
    while (xfer_count < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput(name, xfer_count, target);
  endtask

  initial begin
    rst_n = 1'b0;
    filter_type = 2'b00;
    lcd_bus.lcd_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
          stall = 1'b0;
        end else begin
          if (stall) begin
            checkOutput("stall hold", int'({lcd_bus.lcd_valid, lcd_bus.lcd_rs, lcd_bus.lcd_data}),
                        int'({1'b1, held}));
          end
          if (lcd_bus.lcd_valid && lcd_bus.lcd_ready) begin
            logic [8:0] exp;
            exp = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
            checkOutput($sformatf("byte %0d", xfer_count), int'({lcd_bus.lcd_rs, lcd_bus.lcd_data}), int'(exp));
            xfer_count++;
            xfer_cyc.push_back(cyc);
          end
          stall = lcd_bus.lcd_valid && !lcd_bus.lcd_ready;
          held  = {lcd_bus.lcd_rs, lcd_bus.lcd_data};
        end
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset valid", int'(lcd_bus.lcd_valid), 0);
    checkOutput("reset rs", int'(lcd_bus.lcd_rs), 0);
    checkOutput("reset data", int'(lcd_bus.lcd_data), 0);
    checkOutput("reset shown", int'(shown_type), 0);
    checkOutput("reset busy", int'(busy), 1);

    // Power-on sequence then first update to NO FILTER
    pushStartup("NO FILTER");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    release_cyc = cyc;
    waitXfers(21, 200, "startup transfers");
    checkOutput("startup latency", xfer_cyc[0] - release_cyc, 11);
    checkOutput("clear wait gap", xfer_cyc[3] - xfer_cyc[2], 6);
    @(negedge clk);
    checkOutput("idle busy", int'(busy), 0);
    checkOutput("idle valid", int'(lcd_bus.lcd_valid), 0);
    checkOutput("shown after startup", int'(shown_type), 0);
    checkOutput("queue drained 1", sb.size(), 0);

    // IDLE -> BLUR at full speed
    pushName("BLUR");
    base = xfer_count;
    applyStimulus(2'b10, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("update entry busy", int'(busy), 1);
    checkOutput("update entry header", int'({lcd_bus.lcd_valid, lcd_bus.lcd_rs, lcd_bus.lcd_data}), 10'h280);
    waitXfers(base + 17, 100, "blur transfers");
    checkOutput("blur 17 cycles", xfer_cyc[base + 16] - xfer_cyc[base], 16);
    @(negedge clk);
    checkOutput("shown blur", int'(shown_type), 2);
    checkOutput("busy after blur", int'(busy), 0);

    // Back to NO FILTER, then BLUR again with a stalling writer
    pushName("NO FILTER");
    base = xfer_count;
    applyStimulus(2'b00, 1'b1);
    waitXfers(base + 17, 100, "no filter transfers");
    pushName("BLUR");
    base = xfer_count;
    applyStimulus(2'b10, 1'b0);
    for (int n = 0; n < 400 && xfer_count < base + 17; n++) begin
      lcd_bus.lcd_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    checkOutput("random ready transfers", xfer_count, base + 17);
    lcd_bus.lcd_ready = 1'b1;
    @(negedge clk);
    checkOutput("shown blur stalled", int'(shown_type), 2);
    checkOutput("queue drained 2", sb.size(), 0);

    // Change request in the middle of an INVERT update
    pushName("INVERT");
    pushName("EDGE DETECT");
    base = xfer_count;
    applyStimulus(2'b11, 1'b1);
    waitXfers(base + 5, 100, "invert first bytes");
    filter_type = 2'b01;
    waitXfers(base + 17, 100, "invert transfers");
    @(negedge clk);
    checkOutput("shown invert", int'(shown_type), 3);
    checkOutput("idle between updates", int'(busy), 0);
    waitXfers(base + 34, 100, "edge transfers");
    @(negedge clk);
    checkOutput("shown edge", int'(shown_type), 1);
    checkOutput("queue drained 3", sb.size(), 0);

    // Reset during a stalled header byte
    applyStimulus(2'b00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("stalled before reset", int'(lcd_bus.lcd_valid), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    pushStartup("NO FILTER");
    base = xfer_count;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lcd_bus.lcd_ready = 1'b1;
    release_cyc = cyc;
    @(negedge clk);
    checkOutput("post reset valid", int'(lcd_bus.lcd_valid), 0);
    checkOutput("post reset shown", int'(shown_type), 0);
    checkOutput("post reset busy", int'(busy), 1);
    waitXfers(base + 21, 200, "restart transfers");
    checkOutput("restart latency", xfer_cyc[base] - release_cyc, 11);
    @(negedge clk);
    checkOutput("restart shown", int'(shown_type), 0);
    checkOutput("restart busy", int'(busy), 0);
    checkOutput("queue drained 4", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
